// File: rtl/stereo_sad_engine_if.sv
// Handshake and data bundle between the line-buffer front end, the SAD engine and the
// disparity-map writer.
interface stereo_sad_engine_if #(
  parameter int unsigned MASK_SIZE     = 5,
  parameter int unsigned MATCH_WIDE    = 18,
  parameter int unsigned POSITION_BITS = 8,
  parameter int unsigned COST_BITS     = 13,
  parameter int unsigned DISP_BITS     = 8
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [8*MASK_SIZE*MASK_SIZE-1:0]      flattern_mask;
  logic [8*MASK_SIZE*MATCH_WIDE-1:0]     flattern_match_array;
  logic [POSITION_BITS-1:0]              mask_position;
  logic [POSITION_BITS-1:0]              match_position;
  logic [POSITION_BITS-1:0]              max_disp;
  logic [COST_BITS-1:0]                  cost_thresh;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [DISP_BITS-1:0]                  DISSPARITION;
  logic [COST_BITS-1:0]                  min_cost;
  logic                                  confident;
  logic                                  ambiguous;

  modport master (
    output in_valid, flattern_mask, flattern_match_array, mask_position, match_position,
           max_disp, cost_thresh, out_ready,
    input  in_ready, out_valid, DISSPARITION, min_cost, confident, ambiguous
  );

  modport slave (
    input  in_valid, flattern_mask, flattern_match_array, mask_position, match_position,
           max_disp, cost_thresh, out_ready,
    output in_ready, out_valid, DISSPARITION, min_cost, confident, ambiguous
  );
endinterface

// File: rtl/stereo_sad_engine.sv
// Sequential SAD stereo matcher: scans one candidate offset per clock over a latched mask
// window and match strip, then holds the best disparity until the consumer takes it.
module stereo_sad_engine #(
  parameter int unsigned MASK_SIZE     = 5,
  parameter int unsigned MATCH_WIDE    = 18,
  parameter int unsigned POSITION_BITS = 8,
  parameter int unsigned COST_BITS     = 13,
  parameter int unsigned DISP_BITS     = 8
) (
  input logic                clk,
  input logic                rst_n,
  stereo_sad_engine_if.slave bus
);
  localparam int unsigned MaskW  = 8 * MASK_SIZE * MASK_SIZE;
  localparam int unsigned StripW = 8 * MASK_SIZE * MATCH_WIDE;
  localparam int unsigned ExtW   = (POSITION_BITS + 1 > DISP_BITS) ? POSITION_BITS + 1
                                                                   : DISP_BITS;
  localparam logic [POSITION_BITS-1:0] LastLimit = POSITION_BITS'(MATCH_WIDE - MASK_SIZE);
  localparam logic [ExtW-1:0]          DispMax   = ExtW'((64'd1 << DISP_BITS) - 64'd1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]               state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic [MaskW-1:0]         mask_q;
  logic [StripW-1:0]        strip_q;
  logic [POSITION_BITS-1:0] mask_pos_q, match_pos_q, last_q;
  logic [COST_BITS-1:0]     thresh_q;
  logic [POSITION_BITS-1:0] d_q, d_d;
  logic [COST_BITS-1:0]     best_cost_q, best_cost_d;
  logic [POSITION_BITS-1:0] best_d_q, best_d_d;
  logic                     tie_q, tie_d;
  logic                     out_valid_q, out_valid_d;
  logic [DISP_BITS-1:0]     disp_q, disp_d;
  logic [COST_BITS-1:0]     min_cost_q, min_cost_d;
  logic                     confident_q, confident_d;
  logic                     ambiguous_q, ambiguous_d;
  logic                     load;

  assign load = (state_q == StIdle) && in_ready_q && bus.in_valid;

  // SAD of the current candidate offset against the latched window and strip.
  logic [COST_BITS-1:0] sad;
  logic [7:0]           m_px, s_px, abs_px;
  always_comb begin
    sad    = '0;
    m_px   = '0;
    s_px   = '0;
    abs_px = '0;
    for (int r = 0; r < int'(MASK_SIZE); r++) begin
      for (int c = 0; c < int'(MASK_SIZE); c++) begin
        m_px   = mask_q[8*(r*int'(MASK_SIZE)+c) +: 8];
        s_px   = strip_q[8*(r*int'(MATCH_WIDE)+c+int'(d_q)) +: 8];
        abs_px = (m_px > s_px) ? (m_px - s_px) : (s_px - m_px);
        sad    = sad + COST_BITS'(abs_px);
      end
    end
  end

  // Running best including this cycle's candidate; strict less-than keeps the lowest offset.
  logic [COST_BITS-1:0]     cand_cost;
  logic [POSITION_BITS-1:0] cand_d;
  logic                     cand_tie;
  logic [POSITION_BITS:0]   sum_pos;
  logic signed [POSITION_BITS:0] diff;
  logic [ExtW-1:0]          diff_ext;
  logic [DISP_BITS-1:0]     disp_sat;
  always_comb begin
    cand_cost = best_cost_q;
    cand_d    = best_d_q;
    cand_tie  = tie_q;
    if (sad < best_cost_q) begin
      cand_cost = sad;
      cand_d    = d_q;
      cand_tie  = 1'b0;
    end else if ((sad == best_cost_q) && (d_q != '0)) begin
      cand_tie = 1'b1;
    end
    sum_pos  = {1'b0, match_pos_q} + {1'b0, cand_d};
    diff     = $signed({1'b0, mask_pos_q}) - $signed(sum_pos);
    diff_ext = ExtW'($unsigned(diff));
    if (diff[POSITION_BITS]) begin
      disp_sat = '0;
    end else if (diff_ext > DispMax) begin
      disp_sat = '1;
    end else begin
      disp_sat = diff_ext[DISP_BITS-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    d_d         = d_q;
    best_cost_d = best_cost_q;
    best_d_d    = best_d_q;
    tie_d       = tie_q;
    out_valid_d = out_valid_q;
    disp_d      = disp_q;
    min_cost_d  = min_cost_q;
    confident_d = confident_q;
    ambiguous_d = ambiguous_q;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (load) begin
          in_ready_d  = 1'b0;
          state_d     = StScan;
          d_d         = '0;
          best_cost_d = '1;
          best_d_d    = '0;
          tie_d       = 1'b0;
        end
      end
      StScan: begin
        best_cost_d = cand_cost;
        best_d_d    = cand_d;
        tie_d       = cand_tie;
        if (d_q == last_q) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          disp_d      = disp_sat;
          min_cost_d  = cand_cost;
          confident_d = (cand_cost <= thresh_q);
          ambiguous_d = cand_tie;
        end else begin
          d_d = d_q + POSITION_BITS'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      d_q         <= '0;
      best_cost_q <= '0;
      best_d_q    <= '0;
      tie_q       <= 1'b0;
      out_valid_q <= 1'b0;
      disp_q      <= '0;
      min_cost_q  <= '0;
      confident_q <= 1'b0;
      ambiguous_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      d_q         <= d_d;
      best_cost_q <= best_cost_d;
      best_d_q    <= best_d_d;
      tie_q       <= tie_d;
      out_valid_q <= out_valid_d;
      disp_q      <= disp_d;
      min_cost_q  <= min_cost_d;
      confident_q <= confident_d;
      ambiguous_q <= ambiguous_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      strip_q     <= '0;
      mask_pos_q  <= '0;
      match_pos_q <= '0;
      thresh_q    <= '0;
      last_q      <= '0;
    end else if (load) begin
      mask_q      <= bus.flattern_mask;
      strip_q     <= bus.flattern_match_array;
      mask_pos_q  <= bus.mask_position;
      match_pos_q <= bus.match_position;
      thresh_q    <= bus.cost_thresh;
      last_q      <= (bus.max_disp > LastLimit) ? LastLimit : bus.max_disp;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.DISSPARITION = disp_q;
  assign bus.min_cost     = min_cost_q;
  assign bus.confident    = confident_q;
  assign bus.ambiguous    = ambiguous_q;
endmodule

// File: tb/tb_stereo_sad_engine.sv
// Scoreboard bench for stereo_sad_engine: directed cases plus randomized transactions
// checked against a brute-force SAD search model.
module tb_stereo_sad_engine;
  localparam int MS = 5, MW = 18, PB = 8, CB = 13, DB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stereo_sad_engine_if #(.MASK_SIZE(MS), .MATCH_WIDE(MW), .POSITION_BITS(PB),
                         .COST_BITS(CB), .DISP_BITS(DB)) sad_if ();

  stereo_sad_engine #(.MASK_SIZE(MS), .MATCH_WIDE(MW), .POSITION_BITS(PB),
                      .COST_BITS(CB), .DISP_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sad_if)
  );

  typedef struct {
    int disp;
    int cost;
    int conf;
    int amb;
    int last;
    int acc_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 2;  // 0 random, 1 always ready, 2 driven by the main sequence

  logic [7:0] m_mask  [MS][MS];
  logic [7:0] m_strip [MS][MW];
  int         mpos, mtpos, mdisp, thr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Exhaustive search over the clamped candidate range; ties counted explicitly.
  function automatic exp_t model();
    exp_t e;
    int best = -1, bd = 0, nbest = 0, last, sad, a;
    last = (mdisp > MW - MS) ? MW - MS : mdisp;
    for (int d = 0; d <= last; d++) begin
      sad = 0;
      for (int r = 0; r < MS; r++)
        for (int c = 0; c < MS; c++) begin
          a = int'(m_mask[r][c]) - int'(m_strip[r][c+d]);
          sad += (a < 0) ? -a : a;
        end
      if (best < 0 || sad < best) begin
        best = sad; bd = d; nbest = 1;
      end else if (sad == best) begin
        nbest++;
      end
    end
    e.disp = mpos - (mtpos + bd);
    if (e.disp < 0) e.disp = 0;
    if (e.disp > 255) e.disp = 255;
    e.cost = best;
    e.conf = (best <= thr) ? 1 : 0;
    e.amb  = (nbest > 1) ? 1 : 0;
    e.last = last;
    e.acc_edge = 0;
    return e;
  endfunction

  task automatic clear_px();
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) m_mask[r][c] = 8'd0;
      for (int c = 0; c < MW; c++) m_strip[r][c] = 8'd0;
    end
  endtask

  task automatic set_diag();
    logic [7:0] dv [MS];
    dv = '{8'd1, 8'd5, 8'd4, 8'd6, 8'd8};
    clear_px();
    for (int r = 0; r < MS; r++) begin
      m_mask[r][r]    = dv[r];
      m_strip[r][r+1] = dv[r];
    end
  endtask

  task automatic rand_txn();
    int kind, hi, off;
    kind = int'($urandom_range(0, 2));
    hi   = (kind == 0) ? 255 : ((kind == 1) ? 3 : 0);
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) m_mask[r][c] = 8'($urandom_range(0, hi));
      for (int c = 0; c < MW; c++) m_strip[r][c] = 8'($urandom_range(0, hi));
    end
    if ($urandom_range(0, 1) == 1) begin
      off = int'($urandom_range(0, MW - MS));
      for (int r = 0; r < MS; r++)
        for (int c = 0; c < MS; c++) m_strip[r][c+off] = m_mask[r][c];
    end
    mpos  = int'($urandom_range(0, 255));
    mtpos = int'($urandom_range(0, 100));
    mdisp = ($urandom_range(0, 4) == 0) ? 255 : int'($urandom_range(0, 15));
    thr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6375))
                                        : int'($urandom_range(0, 300));
  endtask

  task automatic present();
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) sad_if.flattern_mask[8*(r*MS+c) +: 8] = m_mask[r][c];
      for (int c = 0; c < MW; c++)
        sad_if.flattern_match_array[8*(r*MW+c) +: 8] = m_strip[r][c];
    end
    sad_if.mask_position  = PB'(mpos);
    sad_if.match_position = PB'(mtpos);
    sad_if.max_disp       = PB'(mdisp);
    sad_if.cost_thresh    = CB'(thr);
    sad_if.in_valid       = 1'b1;
  endtask

  // dir=1 takes the expected result from the caller instead of the model.
  task automatic wait_accept(input bit dir, input int ed, input int ec, input int ecf,
                             input int eam);
    exp_t e;
    bit   ok = 1'b0;
    e = model();
    if (dir) begin
      e.disp = ed; e.cost = ec; e.conf = ecf; e.amb = eam;
    end
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (sad_if.in_ready) begin
        ok = 1'b1;
        e.acc_edge = cyc + 1;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    sad_if.in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 400 cycles");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (sb.size() != 0 || sad_if.out_valid); i++) begin
      @(posedge clk); #1;
    end
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0) sad_if.out_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 1) sad_if.out_ready = 1'b1;
  end

  // Monitor: pops on each result handshake, checks latency, hold stability and in_ready.
  exp_t       me;
  bit         was_valid = 1'b0, prev_ready = 1'b0, hs_prev = 1'b0;
  int         rise_cyc = 0;
  logic [DB-1:0] s_disp;
  logic [CB-1:0] s_cost;
  logic [1:0]    s_flags;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      was_valid = 1'b0; prev_ready = 1'b0; hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("in_ready_after_result", 32'(sad_if.in_ready), 32'd1);
      hs_prev = 1'b0;
      if (was_valid && !prev_ready) begin
        chk("hold_valid", 32'(sad_if.out_valid), 32'd1);
        chk("hold_disp", 32'(sad_if.DISSPARITION), 32'(s_disp));
        chk("hold_cost", 32'(sad_if.min_cost), 32'(s_cost));
        chk("hold_flags", 32'({sad_if.confident, sad_if.ambiguous}), 32'(s_flags));
      end
      if (sad_if.out_valid) begin
        if (!was_valid) rise_cyc = cyc;
        chk("busy_in_ready_low", 32'(sad_if.in_ready), 32'd0);
        if (sad_if.out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: out_valid got 1 expected 0 (disparity %0d)",
                     sad_if.DISSPARITION);
          end else begin
            me = sb.pop_front();
            chk("latency", 32'(rise_cyc - me.acc_edge), 32'(me.last + 1));
            chk("disparity", 32'(sad_if.DISSPARITION), 32'(me.disp));
            chk("min_cost", 32'(sad_if.min_cost), 32'(me.cost));
            chk("confident", 32'(sad_if.confident), 32'(me.conf));
            chk("ambiguous", 32'(sad_if.ambiguous), 32'(me.amb));
          end
          hs_prev = 1'b1;
        end
      end
      was_valid  = sad_if.out_valid;
      prev_ready = sad_if.out_ready;
      s_disp     = sad_if.DISSPARITION;
      s_cost     = sad_if.min_cost;
      s_flags    = {sad_if.confident, sad_if.ambiguous};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(sad_if.in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(sad_if.out_valid), 32'd0);
    chk({tag, "_disp"}, 32'(sad_if.DISSPARITION), 32'd0);
    chk({tag, "_cost"}, 32'(sad_if.min_cost), 32'd0);
    chk({tag, "_conf"}, 32'(sad_if.confident), 32'd0);
    chk({tag, "_amb"}, 32'(sad_if.ambiguous), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    sad_if.in_valid = 1'b0;
    sad_if.out_ready = 1'b0;
    sad_if.flattern_mask = '0;
    sad_if.flattern_match_array = '0;
    sad_if.mask_position = '0;
    sad_if.match_position = '0;
    sad_if.max_disp = '0;
    sad_if.cost_thresh = '0;
    clear_px();
    #1 rst_n = 1'b0;
    #2 chk_zero_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("in_ready_before_edge", 32'(sad_if.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_first_edge", 32'(sad_if.in_ready), 32'd1);

    rdy_mode = 1;
    set_diag(); mpos = 15; mtpos = 0; mdisp = 255; thr = 0;
    present(); wait_accept(1'b1, 14, 0, 1, 0);
    mdisp = 0;
    present(); wait_accept(1'b1, 15, 40, 0, 0);
    clear_px(); mdisp = 255;
    present(); wait_accept(1'b1, 15, 0, 1, 1);
    set_diag(); mpos = 0; mtpos = 0;
    present(); wait_accept(1'b1, 0, 0, 1, 0);
    wait_drain();

    // Back-pressure with a second transaction waiting on in_valid.
    rdy_mode = 2;
    sad_if.out_ready = 1'b0;
    set_diag(); mpos = 15; mtpos = 0; mdisp = 255; thr = 0;
    present(); wait_accept(1'b1, 14, 0, 1, 0);
    for (int i = 0; i < 100 && !sad_if.out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", 32'(sad_if.out_valid), 32'd1);
    rand_txn(); present();
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready_low", 32'(sad_if.in_ready), 32'd0);
      chk("bp_valid_held", 32'(sad_if.out_valid), 32'd1);
    end
    sad_if.out_ready = 1'b1;
    @(posedge clk); #1;
    sad_if.out_ready = 1'b0;
    chk("bp_in_ready_after_hs", 32'(sad_if.in_ready), 32'd1);
    chk("bp_valid_dropped", 32'(sad_if.out_valid), 32'd0);
    wait_accept(1'b0, 0, 0, 0, 0);
    rdy_mode = 1;
    wait_drain();

    rdy_mode = 0;
    repeat (40) begin
      rand_txn(); present(); wait_accept(1'b0, 0, 0, 0, 0);
    end
    wait_drain();

    // Reset in the middle of a scan, with a non-zero previous result still held.
    rdy_mode = 1;
    set_diag(); mpos = 15; mtpos = 0; mdisp = 0; thr = 0;
    present(); wait_accept(1'b1, 15, 40, 0, 0);
    wait_drain();
    mdisp = 255;
    present(); wait_accept(1'b1, 14, 0, 1, 0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1 chk_zero_outputs("midscan_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(sad_if.in_ready), 32'd1);
    chk("post_reset_no_valid", 32'(sad_if.out_valid), 32'd0);
    rand_txn(); present(); wait_accept(1'b0, 0, 0, 0, 0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
